mpu_transpose_ctrl: RTL and testbench

Sequencing controller for the 5x5 signed 8-bit transpose datapath in the matrix processing unit. It collects a 25-element matrix from a byte stream, presents it to the combinational transpose unit, captures the result after a fixed settle interval, and streams the transposed matrix back out. It sits between the MPU's memory/bus side and the transpose unit, which it drives through a flat 200-bit port pair.

---
 rtl/mpu_transpose_ctrl.sv | 155 +++++++++++++++
 tb/tb_mpu_transpose_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_transpose_ctrl.sv
// mpu_transpose_ctrl
// Sequencing controller for the 5x5 signed 8-bit transpose datapath. It collects
// 25 elements row-major from a byte stream into a matrix register and presents
// that register to the combinational transpose unit. It captures the unit's result
// after EXEC_WAIT cycles, then streams the 25 result elements out.
//
// Parameters:
//   EXEC_WAIT  cycles spent in EXEC before op_result is captured (1..15)
// Optional feature macro:
//   MPU_CTRL_ABORT_EN  adds the abort input (drop the current job, return to IDLE)
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   start, busy, done       job request / not-idle / one-cycle completion pulse
//   in_data/valid/ready     element input stream (row-major, element (0,0) first)
//   out_data/valid/ready    result element output stream
//   op_matrix, op_result    200-bit port pair to the transpose unit,
//                           element (r,c) at bits [8*(5r+c) +: 8]
//   abort                   only with MPU_CTRL_ABORT_EN
module mpu_transpose_ctrl #(
    parameter int unsigned EXEC_WAIT = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [199:0] op_matrix,
`ifdef MPU_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic [199:0] op_result
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExec,
        StStore
    } state_e;

    localparam logic [4:0] LastIdx  = 5'd24;
    localparam logic [3:0] WaitLast = 4'(EXEC_WAIT - 1);

    state_e         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [3:0]     wait_q, wait_d;
    logic [199:0]   matrix_q;
    logic [199:0]   result_q;
    logic           done_q, done_d;
    logic           load_we;
    logic           capture;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        done_d    = 1'b0;
        load_we   = 1'b0;
        capture   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_we = 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = StExec;
                        idx_d   = '0;
                        wait_d  = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StExec: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == WaitLast) begin
                    capture = 1'b1;
                    state_d = StStore;
                    idx_d   = '0;
                    wait_d  = '0;
                end
            end
            StStore: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef MPU_CTRL_ABORT_EN
        // Abort wins over any handshake in the same cycle; the element is dropped
        // and both data registers keep what they already hold.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            idx_d   = '0;
            wait_d  = '0;
            load_we = 1'b0;
            capture = 1'b0;
            done_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            wait_q   <= '0;
            matrix_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            if (load_we) begin
                matrix_q[{idx_q, 3'b000} +: 8] <= in_data;
            end
            if (capture) begin
                result_q <= op_result;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign op_matrix = matrix_q;
    // Combinational read from the registered index keeps out_data stable under stall.
    assign out_data  = result_q[{idx_q, 3'b000} +: 8];

endmodule

// File: tb/tb_mpu_transpose_ctrl.sv
// Self-checking bench for mpu_transpose_ctrl. A behavioural transpose unit is
// attached to each DUT. Expected output elements are pushed into a queue by the
// stimulus and popped by a monitor on every output handshake.
module tb_mpu_transpose_ctrl;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         busy;
    logic         done;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic [199:0] op_matrix;
    logic [199:0] op_result;
    logic         abort;

    // Second instance with a longer settle interval.
    logic         start3;
    logic         busy3;
    logic         done3;
    logic         in_ready3;
    logic [7:0]   out_data3;
    logic         out_valid3;
    logic [199:0] op_matrix3;
    logic [199:0] op_result3;

    int n_checks;
    int n_fail;
    int cyc;
    int done_cnt;
    int done_cyc;
    logic [7:0] exp_q[$];

    function automatic logic [199:0] transpose(input logic [199:0] m);
        logic [199:0] t;
        t = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                t[8*(5*c+r) +: 8] = m[8*(5*r+c) +: 8];
            end
        end
        return t;
    endfunction

    assign op_result  = transpose(op_matrix);
    assign op_result3 = transpose(op_matrix3);

    mpu_transpose_ctrl #(.EXEC_WAIT(1)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_matrix (op_matrix),
`ifdef MPU_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .op_result (op_result)
    );

    mpu_transpose_ctrl #(.EXEC_WAIT(3)) u_dut3 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start3),
        .busy      (busy3),
        .done      (done3),
        .in_data   (8'h5a),
        .in_valid  (1'b1),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (1'b1),
        .op_matrix (op_matrix3),
`ifdef MPU_CTRL_ABORT_EN
        .abort     (1'b0),
`endif
        .op_result (op_result3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic monitor();
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (prev_stall && out_valid) check("out_data_stable", 200'(out_data),
                                                   200'(prev_data));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %0d, expected no output",
                                 $signed(out_data));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 200'(out_data), 200'(e));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    endtask

    // One job on the main DUT. busy_start_at / abort_at / reset_at < 0 disable
    // the corresponding disturbance; exp_len <= 0 skips the latency check.
    task automatic run_job(input logic [7:0] m[25], input logic [7:0] e[25], input bit rnd,
                           input int busy_start_at, input int abort_at, input int reset_at,
                           input int exp_len);
        int k;
        int guard;
        int t0;
        int dc0;
        bit hs;
        dc0 = done_cnt;
        if (abort_at < 0) begin
            for (int i = 0; i < 25; i++) exp_q.push_back(e[i]);
        end
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        check("busy_after_start", 200'(busy), 200'(1));
        check("in_ready_after_start", 200'(in_ready), 200'(1));

        k = 0;
        guard = 0;
        while (k < 25 && guard < 3000) begin
            in_data  = m[k];
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = (k == busy_start_at);
            if (k == abort_at) begin
                in_valid = 1'b1;
                abort    = 1'b1;
            end
            @(negedge clock);
            hs = in_valid && in_ready;
            tick();
            if (abort) begin
                abort    = 1'b0;
                in_valid = 1'b0;
                check("abort_busy", 200'(busy), 200'(0));
                check("abort_in_ready", 200'(in_ready), 200'(0));
                return;
            end
            if (hs) k++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("load_completed", 200'(k), 200'(25));

        guard = 0;
        while (done_cnt == dc0 && guard < 3000) begin
            if (reset_at >= 0 && exp_q.size() == 25 - reset_at) begin
                check("pre_reset_out_data", 200'(out_data), 200'(e[reset_at]));
                reset_n = 1'b0;
                #1;
                check("rst_busy", 200'(busy), 200'(0));
                check("rst_done", 200'(done), 200'(0));
                check("rst_in_ready", 200'(in_ready), 200'(0));
                check("rst_out_valid", 200'(out_valid), 200'(0));
                check("rst_out_data", 200'(out_data), 200'(0));
                check("rst_op_matrix", op_matrix, 200'(0));
                exp_q.delete();
                repeat (3) tick();
                check("no_done_after_reset", 200'(done_cnt), 200'(dc0));
                reset_n = 1'b1;
                tick();
                return;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            guard++;
        end
        out_ready = 1'b1;
        check("done_seen", 200'(done_cnt), 200'(dc0 + 1));
        if (exp_len > 0) check("job_latency", 200'(done_cyc - t0), 200'(exp_len));
        repeat (3) tick();
        check("done_single_pulse", 200'(done_cnt), 200'(dc0 + 1));
        check("idle_after_job", 200'(busy), 200'(0));
        check("outputs_drained", 200'(exp_q.size()), 200'(0));
    endtask

    logic [7:0] basic_in[25];
    logic [7:0] basic_out[25];
    logic [7:0] sgn_in[25];
    logic [7:0] sgn_out[25];
    logic [7:0] abt_in[25];

    initial begin
        int te;
        int g;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        done_cnt = 0;
        done_cyc = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        start3    = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        abort     = 1'b0;

        for (int i = 0; i < 25; i++) begin
            basic_in[i] = 8'(i + 1);
            sgn_in[i]   = 8'h00;
            sgn_out[i]  = 8'h00;
            abt_in[i]   = 8'h33;
        end
        basic_out = '{8'd1, 8'd6, 8'd11, 8'd16, 8'd21, 8'd2, 8'd7, 8'd12, 8'd17, 8'd22,
                      8'd3, 8'd8, 8'd13, 8'd18, 8'd23, 8'd4, 8'd9, 8'd14, 8'd19, 8'd24,
                      8'd5, 8'd10, 8'd15, 8'd20, 8'd25};
        sgn_in[4]   = 8'h80;
        sgn_in[20]  = 8'h7f;
        sgn_out[4]  = 8'h7f;
        sgn_out[20] = 8'h80;

        fork
            monitor();
        join_none

        repeat (2) tick();
        check("reset_busy", 200'(busy), 200'(0));
        check("reset_done", 200'(done), 200'(0));
        check("reset_in_ready", 200'(in_ready), 200'(0));
        check("reset_out_valid", 200'(out_valid), 200'(0));
        check("reset_out_data", 200'(out_data), 200'(0));
        check("reset_op_matrix", op_matrix, 200'(0));
        reset_n = 1'b1;
        repeat (2) tick();

        // Basic job: 1 + 25 + 1 + 25 cycles to done.
        run_job(basic_in, basic_out, 1'b0, -1, -1, -1, 52);
        // Signed extremes pass through bit-exact.
        run_job(sgn_in, sgn_out, 1'b0, -1, -1, -1, 52);
        // Random backpressure on both streams.
        run_job(basic_in, basic_out, 1'b1, -1, -1, -1, 0);
        // start pulsed mid-load must not queue a second job.
        run_job(basic_in, basic_out, 1'b0, 10, -1, -1, 52);
        // Reset while output index 10 is presented, then a clean job.
        run_job(basic_in, basic_out, 1'b0, -1, -1, 10, 0);
        run_job(basic_in, basic_out, 1'b0, -1, -1, -1, 52);

`ifdef MPU_CTRL_ABORT_EN
        begin
            int dca;
            dca = done_cnt;
            run_job(abt_in, abt_in, 1'b0, -1, 7, -1, 0);
            check("abort_keeps_new_slot6", 200'(op_matrix[8*6 +: 8]), 200'(8'h33));
            check("abort_drops_slot7", 200'(op_matrix[8*7 +: 8]), 200'(8'd8));
            repeat (3) tick();
            check("abort_no_done", 200'(done_cnt), 200'(dca));
            run_job(basic_in, basic_out, 1'b0, -1, -1, -1, 52);
        end
`endif

        // EXEC_WAIT=3: out_valid rises 3 edges after the last load handshake.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("dut3_busy_after_start", 200'(busy3), 200'(1));
        g = 0;
        while (in_ready3 && g < 100) begin
            tick();
            g++;
        end
        te = cyc;
        g = 0;
        while (!out_valid3 && g < 100) begin
            tick();
            g++;
        end
        check("dut3_exec_latency", 200'(cyc - te), 200'(3));
        check("dut3_first_out", 200'(out_data3), 200'(8'h5a));
        g = 0;
        while (busy3 && g < 100) begin
            tick();
            g++;
        end
        check("dut3_back_to_idle", 200'(busy3), 200'(0));

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
